// File: rtl/fast_command_encoder.sv
// Fast-command serialiser: picks one 8-bit word per frame (L1A > orbit > queued > idle)
// and shifts it out MSB first, one bit per clk320 cycle.
module fast_command_encoder #(
  parameter logic [7:0] IDLE_CODE  = 8'hAC,
  parameter logic [7:0] L1A_CODE   = 8'h4B,
  parameter logic [7:0] ORBIT_CODE = 8'h2D,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk320,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       l1a_req,
  input  logic       orbit_req,
  input  logic       FC_invert,
  output logic       FC_out,
  output logic       frame_start,
  output logic       sent_strobe,
  output logic [1:0] sent_type,
  output logic       req_collision
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);

  logic [2:0]    r_cnt;
  logic [7:0]    r_shift;
  logic          r_l1a_pend;
  logic          r_orb_pend;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rdy;
  logic          r_strobe;
  logic [1:0]    r_type;
  logic          r_coll;

  logic       w_last;
  logic       w_l1a_any;
  logic       w_orb_any;
  logic       w_sel_l1a;
  logic       w_sel_orb;
  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_l1a_pend_nxt;
  logic       w_orb_pend_nxt;
  logic       w_l1a_coll;
  logic       w_orb_coll;
  logic [7:0] w_next_word;
  logic [1:0] w_next_type;

  // Requests arriving in the last bit cycle take part in that cycle's selection.
  assign w_last    = (r_cnt == 3'd7);
  assign w_l1a_any = r_l1a_pend | l1a_req;
  assign w_orb_any = r_orb_pend | orbit_req;
  assign w_sel_l1a = w_last & w_l1a_any;
  assign w_sel_orb = w_last & ~w_l1a_any & w_orb_any;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL);
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = w_last & ~w_l1a_any & ~w_orb_any & ~w_empty;

  // When the pending word is sent, a same-cycle request becomes the new pending one.
  assign w_l1a_pend_nxt = w_sel_l1a ? (r_l1a_pend & l1a_req)   : w_l1a_any;
  assign w_orb_pend_nxt = w_sel_orb ? (r_orb_pend & orbit_req) : w_orb_any;
  assign w_l1a_coll     = l1a_req   & r_l1a_pend & ~w_sel_l1a;
  assign w_orb_coll     = orbit_req & r_orb_pend & ~w_sel_orb;

  always_comb begin
    w_next_word = IDLE_CODE;
    w_next_type = 2'd0;
    if (w_sel_l1a) begin
      w_next_word = L1A_CODE;
      w_next_type = 2'd3;
    end else if (w_sel_orb) begin
      w_next_word = ORBIT_CODE;
      w_next_type = 2'd2;
    end else if (w_pop) begin
      w_next_word = r_mem[r_rd_ptr];
      w_next_type = 2'd1;
    end
  end

  always_ff @(posedge clk320) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk320 or posedge reset) begin
    if (reset) begin
      r_cnt      <= 3'd0;
      r_shift    <= IDLE_CODE;
      r_l1a_pend <= 1'b0;
      r_orb_pend <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rdy      <= 1'b0;
      r_strobe   <= 1'b0;
      r_type     <= 2'd0;
      r_coll     <= 1'b0;
    end else begin
      r_cnt      <= r_cnt + 3'd1;
      r_rdy      <= 1'b1;
      r_shift    <= w_last ? w_next_word : {r_shift[6:0], 1'b0};
      r_strobe   <= w_last & (w_next_type != 2'd0);
      if (w_last) r_type <= w_next_type;
      r_l1a_pend <= w_l1a_pend_nxt;
      r_orb_pend <= w_orb_pend_nxt;
      r_coll     <= w_l1a_coll | w_orb_coll;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign cmd_ready     = r_rdy & ~w_full;
  assign FC_out        = r_shift[7] ^ FC_invert;
  assign frame_start   = (r_cnt == 3'd0);
  assign sent_strobe   = r_strobe;
  assign sent_type     = r_type;
  assign req_collision = r_coll;

endmodule
